// File: rtl/skintone_ellipse.sv
// Pipelined skin-tone ellipse scorer for {Y,Cr,Cb,aux} pixel words.
// Six-cycle latency, global stall enable, config swapped only on an empty pipe.
module skintone_ellipse #(
  parameter int FRAC_W   = 12,
  parameter int COEF_W   = 16,
  parameter int DEF_COS  = 4091,
  parameter int DEF_SIN  = 199,
  parameter int DEF_CX   = 109,
  parameter int DEF_CY   = 152,
  parameter int DEF_ECX  = 6554,
  parameter int DEF_ECY  = 9871,
  parameter int DEF_AINV = 6,
  parameter int DEF_BINV = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     datain_valid,
  input  logic [31:0]              datain,
  output logic                     datain_ready,
  output logic                     dataout_valid,
  output logic [31:0]              dataout,
  input  logic                     dataout_ready,
  input  logic [1:0]               mode,
  input  logic                     cfg_load,
  input  logic signed [COEF_W-1:0] cfg_cos,
  input  logic signed [COEF_W-1:0] cfg_sin,
  input  logic signed [COEF_W-1:0] cfg_ecx,
  input  logic signed [COEF_W-1:0] cfg_ecy,
  input  logic [COEF_W-1:0]        cfg_ainv,
  input  logic [COEF_W-1:0]        cfg_binv,
  input  logic [7:0]               cfg_cx,
  input  logic [7:0]               cfg_cy,
  output logic                     cfg_busy
);

  localparam int P_W   = COEF_W + 10;
  localparam int E_W   = P_W + 1;
  localparam int SQ_W  = 2 * E_W - 1;
  localparam int ACC_W = SQ_W + COEF_W + 1;
  localparam int D_W   = ACC_W - 2 * FRAC_W;
  localparam logic [FRAC_W:0] UNITY = {1'b1, {FRAC_W{1'b0}}};

  typedef struct packed {
    logic [COEF_W-1:0] cs;
    logic [COEF_W-1:0] sn;
    logic [COEF_W-1:0] ecx;
    logic [COEF_W-1:0] ecy;
    logic [COEF_W-1:0] ainv;
    logic [COEF_W-1:0] binv;
    logic [7:0]        cx;
    logic [7:0]        cy;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    cs:   COEF_W'(DEF_COS),
    sn:   COEF_W'(DEF_SIN),
    ecx:  COEF_W'(DEF_ECX),
    ecy:  COEF_W'(DEF_ECY),
    ainv: COEF_W'(DEF_AINV),
    binv: COEF_W'(DEF_BINV),
    cx:   8'(DEF_CX),
    cy:   8'(DEF_CY)
  };

  cfg_t act;
  cfg_t hold;

  // v[k] marks a live word in stage k; sb carries {mode, Y, Cr, Cb, aux} alongside.
  logic [5:1]  v;
  logic [33:0] sb [1:5];

  logic signed [8:0]     s1_dx, s1_dy;
  logic signed [P_W-1:0] s2_x, s2_y;
  logic signed [E_W-1:0] s3_ex, s3_ey;
  logic [SQ_W-1:0]       s4_ex2, s4_ey2;
  logic [D_W-1:0]        s5_d;

  logic             en, accept, apply;
  logic [1:0]       mode_n;
  logic [E_W-1:0]   ex_mag, ey_mag;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [FRAC_W:0]  rem;
  logic [FRAC_W+7:0] prod;
  logic [7:0]       score, out_byte;

  assign en           = !dataout_valid | dataout_ready;
  assign datain_ready = en & !cfg_busy;
  assign accept       = datain_valid & datain_ready;
  assign apply        = cfg_busy & ~|v;
  assign mode_n       = (mode == 2'd3) ? 2'd0 : mode;

  assign ex_mag = s3_ex[E_W-1] ? $unsigned(-s3_ex) : $unsigned(s3_ex);
  assign ey_mag = s3_ey[E_W-1] ? $unsigned(-s3_ey) : $unsigned(s3_ey);
  assign acc    = ACC_W'(s4_ex2) * ACC_W'(act.ainv) + ACC_W'(s4_ey2) * ACC_W'(act.binv);

  // Only the low FRAC_W+1 bits of d matter once saturation is ruled out.
  assign sat   = |s5_d[D_W-1:FRAC_W];
  assign rem   = UNITY - s5_d[FRAC_W:0];
  assign prod  = (FRAC_W+8)'(rem) * (FRAC_W+8)'(8'd255);
  assign score = sat ? 8'd0 : 8'(prod >> FRAC_W);

  always_comb begin
    out_byte = score;
    case (sb[5][33:32])
      2'd1:    out_byte = (score != 8'd0) ? 8'hFF : 8'h00;
      2'd2:    out_byte = sb[5][7:0];
      default: out_byte = score;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v             <= '0;
      dataout_valid <= 1'b0;
      dataout       <= '0;
      cfg_busy      <= 1'b0;
      act           <= DEF_CFG;
      hold          <= DEF_CFG;
    end else begin
      if (cfg_load) begin
        hold <= '{cs: cfg_cos, sn: cfg_sin, ecx: cfg_ecx, ecy: cfg_ecy,
                  ainv: cfg_ainv, binv: cfg_binv, cx: cfg_cx, cy: cfg_cy};
        cfg_busy <= 1'b1;
      end else if (apply) begin
        cfg_busy <= 1'b0;
      end
      if (apply)
        act <= hold;

      if (en) begin
        v     <= {v[4:1], accept};
        sb[1] <= {mode_n, datain};
        for (int i = 2; i <= 5; i++)
          sb[i] <= sb[i-1];

        s1_dx  <= $signed({1'b0, datain[15:8]}) - $signed({1'b0, act.cx});
        s1_dy  <= $signed({1'b0, datain[23:16]}) - $signed({1'b0, act.cy});
        s2_x   <= P_W'(s1_dx) * P_W'($signed(act.cs)) + P_W'(s1_dy) * P_W'($signed(act.sn));
        s2_y   <= P_W'(s1_dy) * P_W'($signed(act.cs)) - P_W'(s1_dx) * P_W'($signed(act.sn));
        s3_ex  <= E_W'(s2_x) - E_W'($signed(act.ecx));
        s3_ey  <= E_W'(s2_y) - E_W'($signed(act.ecy));
        s4_ex2 <= SQ_W'(ex_mag) * SQ_W'(ex_mag);
        s4_ey2 <= SQ_W'(ey_mag) * SQ_W'(ey_mag);
        s5_d   <= D_W'(acc >> (2 * FRAC_W));

        dataout_valid <= v[5];
        if (v[5])
          dataout <= {sb[5][31:8], out_byte};
      end
    end
  end

endmodule

// File: tb/tb_skintone_ellipse.sv
// Randomised and directed bench for skintone_ellipse against an integer-arithmetic
// ellipse model and an expected-word queue.
module tb_skintone_ellipse;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        datain_valid = 1'b0;
  logic [31:0] datain = '0;
  logic        datain_ready;
  logic        dataout_valid;
  logic [31:0] dataout;
  logic        dataout_ready = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        cfg_load = 1'b0;
  logic signed [15:0] cfg_cos = 16'sd4091;
  logic signed [15:0] cfg_sin = 16'sd199;
  logic signed [15:0] cfg_ecx = 16'sd6554;
  logic signed [15:0] cfg_ecy = 16'sd9871;
  logic [15:0] cfg_ainv = 16'd6;
  logic [15:0] cfg_binv = 16'd21;
  logic [7:0]  cfg_cx = 8'd109;
  logic [7:0]  cfg_cy = 8'd152;
  logic        cfg_busy;

  skintone_ellipse dut (
    .clk(clk), .rst(rst),
    .datain_valid(datain_valid), .datain(datain), .datain_ready(datain_ready),
    .dataout_valid(dataout_valid), .dataout(dataout), .dataout_ready(dataout_ready),
    .mode(mode), .cfg_load(cfg_load),
    .cfg_cos(cfg_cos), .cfg_sin(cfg_sin), .cfg_ecx(cfg_ecx), .cfg_ecy(cfg_ecy),
    .cfg_ainv(cfg_ainv), .cfg_binv(cfg_binv), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
    .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cs, sn, cx, cy, ecx, ecy, ainv, binv;
  } mcfg_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [31:0] exp_q [$];
  mcfg_t       mcfg;
  bit          rand_ready = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic mcfg_t def_cfg();
    mcfg_t c;
    c.cs = 4091; c.sn = 199; c.cx = 109; c.cy = 152;
    c.ecx = 6554; c.ecy = 9871; c.ainv = 6; c.binv = 21;
    return c;
  endfunction

  // Ellipse distance in Q12, then linear fall-off to zero at d = 1.0.
  function automatic logic [7:0] score_of(int cb, int cr, mcfg_t c);
    longint dx, dy, x, y, ex, ey, d;
    dx = cb - c.cx;
    dy = cr - c.cy;
    x  = dx * c.cs + dy * c.sn;
    y  = dy * c.cs - dx * c.sn;
    ex = x - c.ecx;
    ey = y - c.ecy;
    d  = (ex * ex * c.ainv + ey * ey * c.binv) / 64'd16777216;
    if (d >= 4096) return 8'd0;
    return 8'(((4096 - d) * 255) / 4096);
  endfunction

  function automatic logic [31:0] expect_word(logic [31:0] w, logic [1:0] m, mcfg_t c);
    logic [7:0] sc;
    logic [7:0] b;
    sc = score_of(int'(w[15:8]), int'(w[23:16]), c);
    case (m)
      2'd1:    b = (sc != 0) ? 8'hFF : 8'h00;
      2'd2:    b = w[7:0];
      default: b = sc;
    endcase
    return {w[31:8], b};
  endfunction

  always begin
    @(posedge clk);
    #1;
    dataout_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
  end

  // Handshakes complete at the next posedge; sample them half a cycle earlier.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", dataout_valid, 1);
        check("stall_data", dataout, prev_data);
      end
      if (dataout_valid && dataout_ready) begin
        n_out++;
        check("spurious_output", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("stream_word", dataout, exp_q.pop_front());
      end
      prev_stall = dataout_valid && !dataout_ready;
      prev_data  = dataout;
      if (datain_valid && datain_ready)
        exp_q.push_back(expect_word(datain, mode, mcfg));
      if (cfg_load) begin
        mcfg.cs = int'(cfg_cos); mcfg.sn = int'(cfg_sin);
        mcfg.ecx = int'(cfg_ecx); mcfg.ecy = int'(cfg_ecy);
        mcfg.ainv = int'(cfg_ainv); mcfg.binv = int'(cfg_binv);
        mcfg.cx = int'(cfg_cx); mcfg.cy = int'(cfg_cy);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_word(logic [31:0] w, logic [1:0] m);
    bit acc = 0;
    int budget = 0;
    datain = w;
    mode = m;
    datain_valid = 1'b1;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = datain_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    datain_valid = 1'b0;
    check("accept", 32'(acc), 1);
  endtask

  // Single word into an idle pipe with dataout_ready held high.
  task automatic send_check(string tag, logic [7:0] cb, logic [7:0] cr, logic [7:0] aux,
                            logic [1:0] m, logic [7:0] exp_byte);
    bit acc;
    int lat;
    datain = {8'h40, cr, cb, aux};
    mode = m;
    datain_valid = 1'b1;
    @(negedge clk);
    acc = datain_ready;
    @(posedge clk);
    #1;
    datain_valid = 1'b0;
    check({tag, "_accept"}, 32'(acc), 1);
    lat = 1;
    while (!dataout_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 6);
    check(tag, dataout[7:0], exp_byte);
    step(2);
  endtask

  task automatic load_cfg(logic [7:0] cx);
    cfg_cx = cx;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic wait_not_busy(string tag);
    int budget = 0;
    while (cfg_busy && budget < 100) begin
      step();
      budget++;
    end
    check(tag, cfg_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int n0, cyc, bad, cb, cr;
    mcfg = def_cfg();
    step(3);
    check("rst_dataout_valid", dataout_valid, 0);
    check("rst_dataout", dataout, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    rst = 1'b0;
    check("rst_datain_ready", datain_ready, 1);
    step(2);

    send_check("centre_mode0", 8'd109, 8'd152, 8'h00, 2'd0, 8'd246);
    send_check("origin_mode0", 8'd0, 8'd0, 8'h11, 2'd0, 8'd0);
    send_check("origin_mode1", 8'd0, 8'd0, 8'h22, 2'd1, 8'd0);
    send_check("centre_mode1", 8'd109, 8'd152, 8'h33, 2'd1, 8'd255);
    send_check("bypass_mode2", 8'd109, 8'd152, 8'h5A, 2'd2, 8'h5A);
    send_check("reserved_mode3", 8'd109, 8'd152, 8'h44, 2'd3, 8'd246);

    rand_ready = 1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom % 4 == 0) step();
      if ($urandom % 2 == 1) begin
        cb = 109 + int'($urandom_range(0, 30)) - 15;
        cr = 152 + int'($urandom_range(0, 30)) - 15;
      end else begin
        cb = int'($urandom % 256);
        cr = int'($urandom % 256);
      end
      drive_word({8'($urandom), 8'(cr), 8'(cb), 8'($urandom)}, 2'($urandom % 4));
    end
    rand_ready = 0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      step();
      cyc++;
    end
    check("random_drain", exp_q.size(), 0);
    step(3);

    for (int i = 0; i < 4; i++) drive_word({8'h10, 8'd152, 8'd109, 8'h00}, 2'd0);
    n0 = n_out;
    load_cfg(8'd120);
    check("busy_after_load", cfg_busy, 1);
    bad = 0;
    cyc = 0;
    while (cfg_busy && cyc < 100) begin
      if (datain_ready) bad++;
      step();
      cyc++;
    end
    check("busy_released", cfg_busy, 0);
    check("ready_low_while_busy", bad, 0);
    check("old_words_drained", n_out - n0, 4);
    send_check("new_cx_used", 8'd120, 8'd152, 8'h00, 2'd0, 8'd246);

    load_cfg(8'd109);
    check("busy_one_cycle_hi", cfg_busy, 1);
    step();
    check("busy_one_cycle_lo", cfg_busy, 0);
    send_check("cx_restored", 8'd109, 8'd152, 8'h00, 2'd0, 8'd246);

    for (int i = 0; i < 2; i++) drive_word({8'h20, 8'd152, 8'd109, 8'h00}, 2'd0);
    load_cfg(8'd100);
    check("busy_before_second_load", cfg_busy, 1);
    load_cfg(8'd125);
    wait_not_busy("double_load_release");
    send_check("last_load_wins", 8'd125, 8'd152, 8'h00, 2'd0, 8'd246);

    for (int i = 0; i < 3; i++) drive_word({8'h30, 8'd152, 8'd125, 8'h00}, 2'd0);
    load_cfg(8'd130);
    rst = 1'b1;
    step();
    check("midrst_dataout_valid", dataout_valid, 0);
    check("midrst_dataout", dataout, 0);
    check("midrst_cfg_busy", cfg_busy, 0);
    rst = 1'b0;
    exp_q.delete();
    mcfg = def_cfg();
    cfg_cx = 8'd109;
    check("midrst_datain_ready", datain_ready, 1);
    n0 = n_out;
    step(15);
    check("no_stale_words", n_out - n0, 0);
    send_check("defaults_after_rst", 8'd109, 8'd152, 8'h00, 2'd0, 8'd246);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skintone_ellipse.md
# skintone_ellipse

Parametrised, fully pipelined skin-tone likelihood scorer for 32-bit YCrCb pixel streams. It takes lighting-compensated Cr/Cb, rotates and offsets them into the skin ellipse frame, and evaluates the normalised ellipse distance. It writes an 8-bit score into the low byte of the pixel word. It sits in the video pipeline after colour-space conversion and before mask/segmentation logic, and adds run-time ellipse configuration, output modes and full ready/valid backpressure.

## Interface
- FRAC_W, 12: fractional bits of all fixed-point coefficients.
- COEF_W, 16: width of signed coefficient ports.
- DEF_COS, 4091: reset value of cos coefficient (0.9988).
- DEF_SIN, 199: reset value of sin coefficient (0.0486).
- DEF_CX, 109 / DEF_CY, 152: reset ellipse centre in Cb/Cr (integer).
- DEF_ECX, 6554 / DEF_ECY, 9871: reset post-rotation offsets (1.6, 2.41, Q.FRAC_W).
- DEF_AINV, 6 / DEF_BINV, 21: reset 1/a², 1/b² (unsigned, Q.FRAC_W).
- clk input 1: clock.
- rst input 1: synchronous, active-high reset.
- datain_valid input 1: input word valid.
- datain input 32: {Y[31:24], Cr[23:16], Cb[15:8], aux[7:0]}.
- datain_ready output 1: block accepts datain this cycle.
- dataout_valid output 1: output word valid.
- dataout output 32: {Y, Cr, Cb, score[7:0]}.
- dataout_ready input 1: downstream accepts dataout.
- mode input 2: 0 = graded score, 1 = binary mask, 2 = bypass (aux passed), 3 = reserved (treated as 0). Mode is sampled per pixel at acceptance and carried down the pipe.
- cfg_load input 1: single-cycle request to load the cfg_* ports.
- cfg_cos, cfg_sin, cfg_ecx, cfg_ecy input COEF_W signed; cfg_ainv, cfg_binv input COEF_W unsigned; cfg_cx, cfg_cy input 8 unsigned.
- cfg_busy output 1: a load is pending.

## Operation
- Global stall enable: en = !dataout_valid | dataout_ready. datain_ready = en & !cfg_busy. A word is accepted when datain_valid & datain_ready. All stages advance only when en. Bubbles advance as bubbles and are not collapsed.
- S1: dx = Cb − cx, dy = Cr − cy (signed 9 bit).
- S2: x = dx·cos + dy·sin, y = dy·cos − dx·sin (signed, COEF_W+10 bit, Q.FRAC_W, no rounding).
- S3: ex = x − ecx, ey = y − ecy (signed, one extra bit).
- S4: ex², ey² (unsigned, Q.2·FRAC_W).
- S5: d = (ex²·ainv + ey²·binv) >> 2·FRAC_W (unsigned, truncating, Q.FRAC_W). Intermediates are wide enough that nothing overflows.
- S6: if d ≥ 2^FRAC_W then score = 0, else score = ((2^FRAC_W − d)·255) >> FRAC_W.
- Mode 1 output byte is 255 if score ≠ 0, else 0. Mode 2 outputs aux unchanged. Y/Cr/Cb always pass unchanged, delayed alongside.
- Config: cfg_load sets a pending flag, and cfg_busy goes high the next cycle. cfg_* values are captured into hold registers in the cfg_load cycle. The active set is updated from the hold registers in the first cycle in which no stage (S1–S6) holds a valid word. cfg_busy clears in that same cycle.
- Every pixel is computed with a single coherent config set. A cfg_load while cfg_busy overwrites the hold registers (last wins).

## Timing
- Latency: 6 cycles from acceptance to dataout_valid, with no stall. Throughput is 1 pixel/clk.
- Stall: while dataout_valid & !dataout_ready, dataout and all stage registers hold, datain_ready = 0, and datain is ignored.
- Drain for config: if the pipe is empty and there is no stall, cfg_busy is high for exactly 1 cycle after cfg_load. Otherwise it stays high until the last in-flight word has left S6 into dataout.
- Reset: dataout_valid = 0, dataout = 0, all stage valids = 0, cfg_busy = 0. The active and hold config are set to the DEF_* values. datain_ready = 1 in the first cycle after reset.
- Reset mid-stream discards all in-flight words and any pending load.
- Simultaneous cfg_load and acceptance: the accepted word uses the old config, and is drained before the new config is applied.

## Test plan
- Defaults, Cb = 109, Cr = 152, mode 0 -> d = 137, dataout low byte = 246, 6 cycles after acceptance.
- Defaults, Cb = 0, Cr = 0 -> score 0. The same pixel with mode 1 -> 0. Pixel (109,152) with mode 1 -> 255. Mode 2 with aux = 0x5A -> 0x5A.
- 100-pixel random stream with random dataout_ready (50 %) -> output sequence matches a bit-exact model, with no loss or duplication. dataout holds stable while stalled.
- cfg_load (cx = 120) with 4 words in flight -> those 4 words use cx = 109. datain_ready stays low until they drain. The next word uses cx = 120. cfg_busy deasserts on the apply cycle.
- Two cfg_load pulses while busy -> the second value is applied.
- rst asserted with 3 words in flight -> next cycle dataout_valid = 0, dataout = 0, defaults restored, and no stale words appear afterwards.
